// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: direct-mapped table of 2-bit saturating
// counters indexed by PC, FD->X prediction carry, mispredict detection,
// counter training and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int          IDX_BITS = 5,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fd_pc,
    input  logic        fd_is_branch,
    input  logic        stall,
    input  logic        flush,
    input  logic        x_is_branch,
    input  logic        x_br_taken,
    output logic        pred_taken,
    output logic        x_pred_taken,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Saturating increment of a 2-bit direction counter.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Saturating decrement of a 2-bit direction counter.
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Saturating increment of a 32-bit statistics counter (never wraps).
    function automatic logic [31:0] stat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : c + 32'd1;
    endfunction

    logic [1:0]          table_r [ENTRIES];
    logic [31:0]         x_pc_q;
    logic                x_valid_q;
    logic [IDX_BITS-1:0] fd_idx_s;
    logic [IDX_BITS-1:0] x_idx_s;
    logic                res_v_s;
    logic                train_s;
    logic [1:0]          ctr_cur_s;
    logic [1:0]          ctr_next_s;
    logic                unused_pc_bits_s;

    assign fd_idx_s = fd_pc[IDX_BITS+1:2];
    assign x_idx_s  = x_pc_q[IDX_BITS+1:2];

    // PC bits outside the index field do not take part in the lookup (no tags).
    assign unused_pc_bits_s = ^{fd_pc[31:IDX_BITS+2], fd_pc[1:0],
                                x_pc_q[31:IDX_BITS+2], x_pc_q[1:0]};

    // Lookup, resolution qualification and mispredict detection.
    always_comb begin
        pred_taken = 1'b0;
        res_v_s    = 1'b0;
        mispredict = 1'b0;
        train_s    = 1'b0;
        if (fd_is_branch) begin
            pred_taken = table_r[fd_idx_s][1];
        end else begin
            pred_taken = 1'b0;
        end
        res_v_s    = x_is_branch & x_valid_q;
        mispredict = res_v_s & (x_br_taken != x_pred_taken);
        train_s    = res_v_s & ~stall;
    end

    // Next counter value for the entry owned by the X-stage branch.
    always_comb begin
        ctr_cur_s  = table_r[x_idx_s];
        ctr_next_s = ctr_cur_s;
        if (x_br_taken) begin
            ctr_next_s = ctr_inc(ctr_cur_s);
        end else begin
            ctr_next_s = ctr_dec(ctr_cur_s);
        end
    end

    // Counter table: reset to CTR_INIT, trained by resolved X branches.
    // A same-cycle lookup of the trained entry sees the old value (no bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CTR_INIT;
            end
        end else if (train_s) begin
            table_r[x_idx_s] <= ctr_next_s;
        end
    end

    // FD->X pipeline register; flush takes priority over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pc_q       <= 32'd0;
            x_pred_taken <= 1'b0;
            x_valid_q    <= 1'b0;
        end else if (flush) begin
            x_pred_taken <= 1'b0;
            x_valid_q    <= 1'b0;
        end else if (!stall) begin
            x_pc_q       <= fd_pc;
            x_pred_taken <= pred_taken;
            x_valid_q    <= fd_is_branch;
        end
    end

    // Saturating branch and mispredict statistics, updated with training.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (train_s) begin
            branch_cnt <= stat_inc(branch_cnt);
            if (mispredict) begin
                mispred_cnt <= stat_inc(mispred_cnt);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a reference model pushes the
// expected outputs onto a scoreboard queue as each cycle's stimulus is driven,
// and they are popped and compared shortly after.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fd_pc;
    logic        fd_is_branch;
    logic        stall;
    logic        flush;
    logic        x_is_branch;
    logic        x_br_taken;
    logic        pred_taken;
    logic        x_pred_taken;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor #(.IDX_BITS(5), .CTR_INIT(2'b01)) dut (
        .clk          (clk),
        .rst          (rst),
        .fd_pc        (fd_pc),
        .fd_is_branch (fd_is_branch),
        .stall        (stall),
        .flush        (flush),
        .x_is_branch  (x_is_branch),
        .x_br_taken   (x_br_taken),
        .pred_taken   (pred_taken),
        .x_pred_taken (x_pred_taken),
        .mispredict   (mispredict),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pred;
        logic        xpred;
        logic        misp;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];

    int n_vec;
    int n_miscmp;

    // Reference model state
    logic [1:0]  m_tbl [32];
    logic [31:0] m_xpc;
    logic        m_xpred;
    logic        m_xvalid;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 2'b01;
        m_xpc = 32'd0; m_xpred = 1'b0; m_xvalid = 1'b0;
        m_bc = 32'd0;  m_mc = 32'd0;
    endtask

    // Drive one cycle of stimulus, score it, then advance the model past the posedge.
    task automatic step(input logic [31:0] pc, input logic br, input logic st,
                        input logic fl, input logic xb, input logic xt);
        exp_t e;
        exp_t g;
        logic [4:0] fi;
        logic [4:0] xi;
        logic       rv;
        @(negedge clk);
        fd_pc = pc; fd_is_branch = br; stall = st; flush = fl;
        x_is_branch = xb; x_br_taken = xt;
        fi = pc[6:2];
        xi = m_xpc[6:2];
        rv = xb & m_xvalid;
        e.pred  = br & m_tbl[fi][1];
        e.xpred = m_xpred;
        e.misp  = rv & (xt != m_xpred);
        e.bc    = m_bc;
        e.mc    = m_mc;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        check_val("pred_taken",   {31'd0, pred_taken},   {31'd0, g.pred});
        check_val("x_pred_taken", {31'd0, x_pred_taken}, {31'd0, g.xpred});
        check_val("mispredict",   {31'd0, mispredict},   {31'd0, g.misp});
        check_val("branch_cnt",   branch_cnt,            g.bc);
        check_val("mispred_cnt",  mispred_cnt,           g.mc);
        // Model update for the coming posedge
        if (rv && !st) begin
            if (xt) m_tbl[xi] = (m_tbl[xi] == 2'b11) ? 2'b11 : m_tbl[xi] + 2'b01;
            else    m_tbl[xi] = (m_tbl[xi] == 2'b00) ? 2'b00 : m_tbl[xi] - 2'b01;
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
            if (e.misp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
        end
        if (fl) begin
            m_xpred = 1'b0; m_xvalid = 1'b0;
        end else if (!st) begin
            m_xpc = pc; m_xpred = e.pred; m_xvalid = br;
        end
    endtask

    // Fetch a branch at pc, then resolve it with outcome t on the next cycle.
    task automatic fetch_resolve(input logic [31:0] pc, input logic t);
        step(pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, t);
    endtask

    initial begin
        n_vec = 0; n_miscmp = 0;
        rst = 1'b1;
        fd_pc = 32'h100; fd_is_branch = 1'b1; stall = 1'b0; flush = 1'b0;
        x_is_branch = 1'b0; x_br_taken = 1'b0;
        model_reset();

        // 1. Reset state
        #2;
        check_val("rst_pred", {31'd0, pred_taken}, 32'd0);
        check_val("rst_bc", branch_cnt, 32'd0);
        check_val("rst_mc", mispred_cnt, 32'd0);
        check_val("rst_xpred", {31'd0, x_pred_taken}, 32'd0);
        check_val("rst_misp", {31'd0, mispredict}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 2. Two taken resolutions at 0x100
        fetch_resolve(32'h100, 1'b1);   // mispredict, 01->10
        fetch_resolve(32'h100, 1'b1);   // predicted taken, 10->11
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t2_bc", branch_cnt, 32'd2);
        check_val("t2_mc", mispred_cnt, 32'd1);

        // 3. Five not-taken resolutions saturate at 00
        for (int i = 0; i < 5; i++) fetch_resolve(32'h100, 1'b0);
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t3_pred", {31'd0, pred_taken}, 32'd0);

        // 4. Collision: 00->01 first, then train taken from 01 while 0x180 is looked up
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h180, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("t4_pred_same", {31'd0, pred_taken}, 32'd0);
        step(32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t4_pred_next", {31'd0, pred_taken}, 32'd1);

        // 5. Stall with a valid resolution pending, then flush
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t5_flush_misp", {31'd0, mispredict}, 32'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            pc = {22'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00};
            step(pc, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // 6. Mid-stream reset after training 0x100 to 11
        for (int i = 0; i < 3; i++) fetch_resolve(32'h100, 1'b1);
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_pre_pred", {31'd0, pred_taken}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rst_pred", {31'd0, pred_taken}, 32'd0);
        check_val("t6_rst_bc", branch_cnt, 32'd0);
        check_val("t6_rst_mc", mispred_cnt, 32'd0);
        check_val("t6_rst_xpred", {31'd0, x_pred_taken}, 32'd0);
        check_val("t6_rst_misp", {31'd0, mispredict}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_post_pred", {31'd0, pred_taken}, 32'd0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
